// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that feeds one FIFO write port from NREQ packet requesters.
// A grant is held for a whole packet, with a forced release after MAXBEATS beats.
module fifo_wr_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned DATASIZE = 8,
   parameter int unsigned MAXBEATS = 16
) (
   input  logic                     wclk,
   input  logic                     wrst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_last,
   input  logic [NREQ*DATASIZE-1:0] req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     wfull,
   output logic                     wclken,
   output logic [DATASIZE-1:0]      wdata,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     busy
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(MAXBEATS) + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_nx;
   logic [IDW-1:0]  last_q, last_nx;
   logic [IDW-1:0]  gid_nx;
   logic [CW-1:0]   beat_cnt, cnt_nx;
   logic [IDW-1:0]  pick;
   logic            pick_ok;
   logic            xfer;

   // First valid requester after last_q, wrapping modulo NREQ.
   always_comb begin
      int unsigned idx;
      idx     = 0;
      pick    = '0;
      pick_ok = 1'b0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx = (32'(last_q) + i) % NREQ;
         if (!pick_ok && req_valid[IDW'(idx)]) begin
            pick    = IDW'(idx);
            pick_ok = 1'b1;
         end
      end
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state    <= IDLE;
         grant_id <= '0;
         last_q   <= IDW'(NREQ - 1);
         beat_cnt <= '0;
      end else begin
         state    <= state_nx;
         grant_id <= gid_nx;
         last_q   <= last_nx;
         beat_cnt <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      gid_nx    = grant_id;
      last_nx   = last_q;
      cnt_nx    = beat_cnt;
      xfer      = 1'b0;
      wclken    = 1'b0;
      req_ready = '0;
      wdata     = '0;
      case (state)
         IDLE: begin
            if (pick_ok) begin
               gid_nx   = pick;
               cnt_nx   = '0;
               state_nx = GRANT;
            end
         end
         GRANT: begin
            // wfull gates the handshake combinationally so a beat is never dropped.
            xfer                = req_valid[grant_id] & ~wfull;
            wclken              = xfer;
            req_ready[grant_id] = xfer;
            wdata               = req_data[grant_id*DATASIZE +: DATASIZE];
            if (xfer) begin
               cnt_nx = beat_cnt + 1'b1;
               if (req_last[grant_id] || beat_cnt == CW'(MAXBEATS - 1)) begin
                  last_nx  = grant_id;
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == GRANT);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the FIFO memory/write-pointer path between NREQ requesters.
- Each requester sends a packet of beats with a valid/ready handshake.
- The arbiter locks the grant for a whole packet, capped at MAXBEATS beats for fairness, and drives the FIFO write enable and data.
- It sits in the write clock domain, ahead of the FIFO write-side logic.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DATASIZE, 8, data width; matches the FIFO data width.
- MAXBEATS, 16, maximum beats per grant before forced release (1..256).

Ports:
- wclk  input  1  write-domain clock; all state on its rising edge.
- wrst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_last  input  NREQ  per-requester last beat of packet; qualified by req_valid.
- req_data  input  NREQ*DATASIZE  requester i occupies bits [i*DATASIZE +: DATASIZE].
- req_ready  output  NREQ  per-requester beat accepted this cycle.
- wfull  input  1  FIFO full flag from the write-side pointer logic.
- wclken  output  1  FIFO write enable (one beat written per high cycle).
- wdata  output  DATASIZE  FIFO write data.
- grant_id  output  clog2(NREQ)  index of the current or last granted requester.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset (wrst=1 at a wclk edge):
  - state=IDLE, grant_id=0, busy=0, beat_cnt=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority after reset.
  - wclken=0, req_ready=0; wdata is don't-care, but is driven as 0 in IDLE.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, select the first valid index searching last+1, last+2, … modulo NREQ.
  - Register it into grant_id, set busy=1, clear beat_cnt, and go to GRANT.
  - Arbitration costs exactly one cycle; no beat is accepted in IDLE.
- GRANT, with g=grant_id:
  - Beat transfer condition: xfer = req_valid[g] & ~wfull.
  - Combinational outputs: wclken = xfer, req_ready[g] = xfer, all other req_ready = 0, wdata = req_data slice g.
  - A pure combinational path from wfull to wclken and req_ready is required, so no beat is lost when the FIFO fills.
  - On xfer, beat_cnt increments.
  - Release when xfer & (req_last[g] | beat_cnt==MAXBEATS-1): set last=g, busy=0, go to IDLE. grant_id holds its value.
  - req_valid[g] low, or wfull high: hold the grant, no transfer, beat_cnt unchanged.
- Forced release at MAXBEATS:
  - The requester's packet resumes at its next grant.
  - The requester must keep driving its remaining beats; there is no packet-boundary signal to the FIFO.
- Valid requests from non-granted requesters are ignored until the next IDLE cycle.
- Releasing requires one IDLE cycle, so at most one beat per two cycles crosses a grant boundary.
- Back-to-back grants to the same requester are allowed only when no other requester is valid.
- wrst mid-packet: return to IDLE on that edge; the partial packet already written stays in the FIFO. Requesters restart cleanly.
- beat_cnt width is clog2(MAXBEATS)+1; it never wraps because release occurs at MAXBEATS-1.
- Assertions for the bench:
  - wclken implies ~wfull.
  - req_ready is onehot0.
  - wclken equals the OR of req_ready.

Test Plan:
- Reset, then only requester 2 sends 3 beats (0xA1, 0xA2, 0xA3 with last) → grant_id=2 after 1 cycle, wclken high 3 consecutive cycles, wdata=A1, A2, A3, busy drops after the last beat.
- All 4 requesters valid continuously with 1-beat packets → grant order 0, 1, 2, 3, 0, …, each beat preceded by 1 IDLE cycle.
- Requester 1 sends a 20-beat packet with MAXBEATS=16 and requester 3 is valid → 16 beats from 1, then release, then requester 3's packet, then the remaining 4 beats of requester 1.
- wfull asserted for 5 cycles mid-packet → wclken=0 and req_ready=0 during those cycles, beat_cnt frozen, no beat lost, stream resumes the cycle wfull drops.
- Granted requester drops req_valid for 2 cycles → grant held, no write, other valid requesters not served.
- wrst pulsed during beat 2 of a 4-beat packet → next cycle state=IDLE, busy=0, last=NREQ-1, so requester 0 wins the next arbitration.
